// File: rtl/system_pio_in_edge_if.sv
// Avalon-MM register bus between the CPU side (master) and the PIO edge-capture block (slave).
// Handshake: read/write are one-cycle strobes accepted every cycle (no waitrequest); readdata is valid the cycle after read.
interface system_pio_in_edge_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, read, write, writedata, input readdata, irq);
    modport slave  (input address, read, write, writedata, output readdata, irq);
endinterface

// File: rtl/system_pio_in_edge.sv
// Parallel input port: synchronizer, optional per-bit debounce, edge capture with
// RW1C clear, interrupt mask and an Avalon-MM register view.
module system_pio_in_edge #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    system_pio_in_edge_if.slave    bus,
    input  logic [WIDTH-1:0]       in_port
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] ec_q;
    logic [WIDTH-1:0] mask_q;
    logic [31:0]      rdata_mux;
    logic [31:0]      rdata_q;
    logic             wd_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodb
            // Without debounce the last synchronizer stage is the stable value itself.
            assign stable_q = sync_q[SYNC_STAGES-1];
            assign stable_d = sync_q[SYNC_STAGES-2];
        end else begin : g_db
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
            localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

            logic [CNT_W-1:0] cnt_q [WIDTH];
            logic [WIDTH-1:0] sync_last;

            assign sync_last = sync_q[SYNC_STAGES-1];

            always_comb begin
                stable_d = stable_q;
                for (int b = 0; b < WIDTH; b++) begin
                    if (sync_last[b] != stable_q[b] && cnt_q[b] == CNT_LAST)
                        stable_d[b] = sync_last[b];
                end
            end

            // Counter tracks how many consecutive cycles the bit has disagreed; the
            // DEBOUNCE_CYCLES-th disagreeing edge is the one that accepts the change.
            always_ff @(posedge clk) begin
                if (reset) begin
                    stable_q <= '0;
                    for (int b = 0; b < WIDTH; b++) cnt_q[b] <= '0;
                end else begin
                    stable_q <= stable_d;
                    for (int b = 0; b < WIDTH; b++) begin
                        if (sync_last[b] == stable_q[b] || cnt_q[b] == CNT_LAST)
                            cnt_q[b] <= '0;
                        else if (cnt_q[b] != CNT_MAX)
                            cnt_q[b] <= cnt_q[b] + 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        if (EDGE_TYPE == 0)      edge_evt = stable_d & ~stable_q;
        else if (EDGE_TYPE == 1) edge_evt = ~stable_d & stable_q;
        else                     edge_evt = stable_d ^ stable_q;
    end

    assign clr_mask  = (bus.write && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
    assign wd_unused = ^bus.writedata;

    // New edges are ORed in after the clear so a coincident set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ec_q   <= '0;
            mask_q <= '0;
        end else begin
            ec_q <= (ec_q & ~clr_mask) | edge_evt;
            if (bus.write && bus.address == 2'd2) mask_q <= bus.writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rdata_mux = '0;
        case (bus.address)
            2'd0:    rdata_mux[WIDTH-1:0] = stable_q;
            2'd2:    rdata_mux[WIDTH-1:0] = mask_q;
            2'd3:    rdata_mux[WIDTH-1:0] = ec_q;
            default: rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)          rdata_q <= '0;
        else if (bus.read)  rdata_q <= rdata_mux;
    end

    assign bus.readdata = rdata_q;
    assign bus.irq      = |(ec_q & mask_q);

endmodule

// File: tb/tb_system_pio_in_edge.sv
// Bench for system_pio_in_edge with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=3, EDGE_TYPE=0.
module tb_system_pio_in_edge;
  localparam int W = 4;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] in_port;
  always #5 clk = ~clk;

  system_pio_in_edge_if bus ();

  system_pio_in_edge #(
    .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3), .EDGE_TYPE(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .in_port(in_port)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string name_q[$];
  logic [31:0] rd_model;
  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // one bus cycle, starting and ending at a negedge; readdata compared after the edge
  task automatic bus_cycle(input logic rd, input logic wr, input logic [1:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input string name);
    bus.read = rd;
    bus.write = wr;
    bus.address = addr;
    bus.writedata = wd;
    if (rd) rd_model = exp_rd;
    exp_q.push_back(rd_model);
    name_q.push_back(name);
    @(posedge clk);
    @(negedge clk);
    bus.read = 1'b0;
    bus.write = 1'b0;
    check(name_q.pop_front(), bus.readdata, exp_q.pop_front());
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 2'd2, 32'hFFFF_FFF1, 32'h0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 32'hF,         32'h0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 2'd1, 32'hF,         32'h0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 32'h0,         32'h5, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 2'd1, 32'h0,         32'h0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 2'd3, 32'h1,         32'h5, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'd3, 32'h0,         32'h4, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'd2, 32'h4,         32'h0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h4, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'd3, 32'h0,         32'h0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'd3, 32'h0,         32'h4, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h0, 1'b0};

    reset = 1'b1;
    in_port = '0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.address = 2'd0;
    bus.writedata = 32'h0;
    rd_model = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_irq", {31'b0, bus.irq}, 32'h0);
    bus_cycle(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, "reset_rd_data");
    bus_cycle(1'b1, 1'b0, 2'd1, 32'h0, 32'h0, "reset_rd_rsvd");
    bus_cycle(1'b1, 1'b0, 2'd2, 32'h0, 32'h0, "reset_rd_mask");
    bus_cycle(1'b1, 1'b0, 2'd3, 32'h0, 32'h0, "reset_rd_ec");

    // 2-cycle glitch on bit0 is rejected
    in_port = 4'h1;
    idle(2, "glitch_hi");
    in_port = 4'h0;
    idle(6, "glitch_lo");
    bus_cycle(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, "glitch_data");
    bus_cycle(1'b1, 1'b0, 2'd3, 32'h0, 32'h0, "glitch_ec");

    // 0x0 -> 0x5: stable changes on the 5th edge, seen by the read on the 6th
    in_port = 4'h5;
    for (int k = 1; k <= 6; k++)
      bus_cycle(1'b1, 1'b0, 2'd0, 32'h0, (k == 6) ? 32'h5 : 32'h0, $sformatf("latency_e%0d", k));
    bus_cycle(1'b1, 1'b0, 2'd3, 32'h0, 32'h5, "ec_after_rise");
    check("irq_unmasked", {31'b0, bus.irq}, 32'h0);

    // register map table: irqmask, RW1C, ignored writes, read-during-write
    for (int i = 0; i < 13; i++) begin
      bus_cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].exp_rd,
                $sformatf("vec%0d_rd", i));
      check($sformatf("vec%0d_irq", i), {31'b0, bus.irq}, {31'b0, vecs[i].exp_irq});
    end

    // clear and new rising edge on bit2 in the same cycle: set wins
    in_port = 4'h1;
    idle(8, "bit2_fall");
    bus_cycle(1'b0, 1'b1, 2'd3, 32'h4, 32'h0, "clr_bit2");
    bus_cycle(1'b1, 1'b0, 2'd3, 32'h0, 32'h0, "ec_cleared");
    in_port = 4'h5;
    idle(4, "bit2_rise_wait");
    bus_cycle(1'b0, 1'b1, 2'd3, 32'h4, 32'h0, "clr_on_edge");
    bus_cycle(1'b1, 1'b0, 2'd3, 32'h0, 32'h4, "set_wins");
    bus_cycle(1'b1, 1'b0, 2'd0, 32'h0, 32'h5, "data_after_rise");
    bus_cycle(1'b0, 1'b1, 2'd3, 32'h4, 32'h0, "clr_again");
    bus_cycle(1'b1, 1'b0, 2'd3, 32'h0, 32'h0, "ec_clear_again");

    // reset mid-debounce discards the pending 0x0 -> 0x8 change
    in_port = 4'h0;
    idle(8, "settle_zero");
    bus_cycle(1'b0, 1'b1, 2'd2, 32'hF, 32'h0, "mask_all");
    bus_cycle(1'b1, 1'b0, 2'd2, 32'h0, 32'hF, "mask_readback");
    in_port = 4'h8;
    idle(3, "debounce_pending");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd_model = 32'h0;
    check("midrst_readdata", bus.readdata, 32'h0);
    check("midrst_irq", {31'b0, bus.irq}, 32'h0);
    bus_cycle(1'b1, 1'b0, 2'd2, 32'h0, 32'h0, "midrst_mask");
    bus_cycle(1'b1, 1'b0, 2'd3, 32'h0, 32'h0, "midrst_ec");
    for (int k = 3; k <= 6; k++)
      bus_cycle(1'b1, 1'b0, 2'd0, 32'h0, (k == 6) ? 32'h8 : 32'h0, $sformatf("midrst_e%0d", k));
    bus_cycle(1'b1, 1'b0, 2'd3, 32'h0, 32'h8, "midrst_ec_set");
    check("midrst_irq_masked", {31'b0, bus.irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/system_pio_in_edge.md
SYSTEM_PIO_IN_EDGE -- requirements
Module: system_pio_in_edge

Interface
REQ-001 Parameter WIDTH, default 8: number of input bits, legal 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per bit, legal 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 0: consecutive stable cycles before a bit change is accepted; 0 bypasses debounce.
REQ-004 Parameter EDGE_TYPE, default 0: edge that sets edgecapture; 0 rising, 1 falling, 2 any.
REQ-005 Port clk  input  1: single clock; all state on rising edge.
REQ-006 Port reset  input  1: synchronous, active-high reset.
REQ-007 Port address  input  2: Avalon-MM word address.
REQ-008 Port read  input  1: read strobe, active-high.
REQ-009 Port write  input  1: write strobe, active-high.
REQ-010 Port writedata  input  32: write data.
REQ-011 Port in_port  input  WIDTH: asynchronous external inputs.
REQ-012 Port readdata  output  32: registered read data.
REQ-013 Port irq  output  1: level interrupt, active-high.

Function
REQ-014 Each in_port bit SHALL pass through SYNC_STAGES flops before any other use.
REQ-015 Per bit, a debounced "stable" value SHALL update to the synchronized value only after the two differ for DEBOUNCE_CYCLES consecutive clocks; any cycle where they match clears that bit's counter to 0.
REQ-016 Per-bit debounce counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter SHALL saturate, never wrap.
REQ-017 With DEBOUNCE_CYCLES=0, stable SHALL equal the last synchronizer stage (total latency SYNC_STAGES clocks from in_port to stable).
REQ-018 Total in_port-to-stable latency SHALL be SYNC_STAGES+DEBOUNCE_CYCLES clocks for an input held constant.
REQ-019 Register map: addr 0 data (RO, stable value); addr 1 reserved (reads 0); addr 2 irqmask (RW); addr 3 edgecapture (RW1C).
REQ-020 An edgecapture bit SHALL set on the same clock edge that its stable bit changes in the direction selected by EDGE_TYPE.
REQ-021 Writing addr 3 SHALL clear each edgecapture bit whose writedata bit is 1; bits written 0 are unchanged.
REQ-022 If a clear and a new qualifying edge hit the same bit in the same cycle, the bit SHALL remain 1 (set wins).
REQ-023 Writing addr 2 SHALL load irqmask from writedata[WIDTH-1:0]; writes to addr 0 and 1 SHALL have no effect.
REQ-024 irq SHALL equal OR of (edgecapture AND irqmask), decoded from registers with no added latency.
REQ-025 readdata SHALL be loaded on the clock edge where read=1, valid from the following cycle (1-cycle latency), and hold when read=0.
REQ-026 readdata bits [31:WIDTH] SHALL read 0; writedata bits [31:WIDTH] SHALL be ignored.
REQ-027 Simultaneous read and write to the same address SHALL return the pre-write value.

Reset
REQ-028 On reset=1 at a clock edge: synchronizer flops, stable, debounce counters, irqmask, edgecapture and readdata SHALL all become 0; irq SHALL be 0.
REQ-029 An input already high at reset release SHALL be treated as a 0->1 transition and captured per EDGE_TYPE.
REQ-030 Reset asserted mid-debounce SHALL discard the pending change; counting restarts from 0 after release.

Verification (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=3, EDGE_TYPE=0)
REQ-031 Reset, in_port=0, read addr 0/2/3 -> readdata 0x0 each, irq 0.
REQ-032 in_port 0x0->0x5 held -> stable=0x5 exactly 5 clocks later; read addr 0 -> 0x5, addr 3 -> 0x5.
REQ-033 in_port bit0 pulsed high 2 clocks -> stable and edgecapture unchanged (0x0).
REQ-034 edgecapture=0x5, write addr 2 = 0x1 -> irq 1; write addr 3 = 0x1 -> edgecapture 0x4, irq 0.
REQ-035 Write addr 3 = 0x4 on the same edge bit2 rises again -> edgecapture bit2 stays 1.
REQ-036 Reset pulsed 1 clock during debounce of 0x0->0x8 -> all registers 0 next cycle; stable=0x8 only 5 clocks after release with in_port held.
